// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decoder/PC side bundle for the control-flow sequencer
//
// Purpose: groups the per-instruction flow-op inputs coming from the decoder and
// the PC load port returned to the program counter.
// Signals:
//   pc_in[15:0]     PC count; word address = pc_in[15:1], phase = pc_in[0]
//   execute_flag    1 = execute phase, 0 = fetch phase
//   op_valid        decoded flow op present
//   op_code[2:0]    flow op encoding
//   op_target[15:0] branch/call target word address
//   cond_zero       datapath zero flag for JZ/JNZ
//   resume          leave the HALT state
//   load_enable     PC load request (combinational)
//   load_addr[15:0] PC load word address (combinational)
// Modports: master = decoder/PC side, slave = sequencer.

interface pc_sequencer_if;
    logic [15:0] pc_in;
    logic        execute_flag;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [15:0] op_target;
    logic        cond_zero;
    logic        resume;
    logic        load_enable;
    logic [15:0] load_addr;

    modport master (
        output pc_in,
        output execute_flag,
        output op_valid,
        output op_code,
        output op_target,
        output cond_zero,
        output resume,
        input  load_enable,
        input  load_addr
    );

    modport slave (
        input  pc_in,
        input  execute_flag,
        input  op_valid,
        input  op_code,
        input  op_target,
        input  cond_zero,
        input  resume,
        output load_enable,
        output load_addr
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter control-flow sequencer with return stack
//
// Purpose: decodes JMP/JZ/JNZ/CALL/RET/HALT in the execute phase, drives the PC
// load port, keeps a hardware return-address stack and holds the core in HALT or
// FAULT by re-loading the current instruction word every execute phase.
// Ports:
//   clk             clock
//   reset           asynchronous, active-high reset
//   bus             pc_sequencer_if.slave (op inputs, PC load outputs)
//   sp[SPW-1:0]     return-stack occupancy, 0..DEPTH
//   halted          state is HALT
//   fault           state is FAULT
//   fault_code[1:0] 01 stack overflow, 10 stack underflow, 00 none

module pc_sequencer #(
    parameter int DEPTH = 8,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    pc_sequencer_if.slave       bus,
    output logic [SPW-1:0]      sp,
    output logic                halted,
    output logic                fault,
    output logic [1:0]          fault_code
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JNZ  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_OVERFLOW  = 2'b01;
    localparam logic [1:0] FC_UNDERFLOW = 2'b10;

    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [1:0]     state_q, state_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [1:0]     fault_code_q, fault_code_d;

    // Return stack storage is deliberately not reset.
    logic [15:0]    stack_mem [0:DEPTH-1];

    logic [15:0]    cur_word;
    logic [15:0]    ret_word;
    logic [SPW-1:0] sp_dec;
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;
    logic [15:0]    stack_top;
    logic           push;
    logic           load_en;
    logic [15:0]    load_word;
    logic           unused_pc_phase;

    // The phase bit is carried separately on execute_flag.
    assign unused_pc_phase = bus.pc_in[0];

    assign cur_word  = {1'b0, bus.pc_in[15:1]};
    assign ret_word  = cur_word + 16'd1;
    assign sp_dec    = sp_q - SPW'(1);
    assign wr_idx    = sp_q[AW-1:0];
    assign rd_idx    = sp_dec[AW-1:0];
    assign stack_top = stack_mem[rd_idx];

    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        fault_code_d = fault_code_q;
        push         = 1'b0;
        load_en      = 1'b0;
        load_word    = cur_word;

        // Nothing changes in the fetch phase.
        if (bus.execute_flag) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.op_valid) begin
                        case (bus.op_code)
                            OP_JMP: begin
                                load_en   = 1'b1;
                                load_word = bus.op_target;
                            end
                            OP_JZ: begin
                                load_en   = bus.cond_zero;
                                load_word = bus.op_target;
                            end
                            OP_JNZ: begin
                                load_en   = ~bus.cond_zero;
                                load_word = bus.op_target;
                            end
                            OP_CALL: begin
                                if (sp_q < SP_FULL) begin
                                    push      = 1'b1;
                                    sp_d      = sp_q + SPW'(1);
                                    load_en   = 1'b1;
                                    load_word = bus.op_target;
                                end else begin
                                    state_d      = ST_FAULT;
                                    fault_code_d = FC_OVERFLOW;
                                end
                            end
                            OP_RET: begin
                                if (sp_q != '0) begin
                                    sp_d      = sp_dec;
                                    load_en   = 1'b1;
                                    load_word = stack_top;
                                end else begin
                                    state_d      = ST_FAULT;
                                    fault_code_d = FC_UNDERFLOW;
                                end
                            end
                            OP_HALT: begin
                                load_en   = 1'b1;
                                load_word = cur_word;
                                state_d   = ST_HALT;
                            end
                            default: begin
                                load_en = 1'b0;
                            end
                        endcase
                    end
                end
                ST_HALT: begin
                    // Releasing the load lets the PC step past the HALT word.
                    if (bus.resume) begin
                        state_d = ST_RUN;
                    end else begin
                        load_en   = 1'b1;
                        load_word = cur_word;
                    end
                end
                ST_FAULT: begin
                    load_en   = 1'b1;
                    load_word = cur_word;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign bus.load_enable = load_en & ~reset;
    assign bus.load_addr   = load_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            sp_q         <= '0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            fault_code_q <= fault_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            stack_mem[wr_idx] <= ret_word;
        end
    end

    assign sp         = sp_q;
    assign halted     = (state_q == ST_HALT);
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer

module tb_pc_sequencer;

    localparam int DEPTH = 8;
    localparam int SPW   = $clog2(DEPTH + 1);

    localparam int M_RUN   = 0;
    localparam int M_HALT  = 1;
    localparam int M_FAULT = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [SPW-1:0] sp;
    logic           halted;
    logic           fault;
    logic [1:0]     fault_code;

    pc_sequencer_if bus ();

    pc_sequencer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sp         (sp),
        .halted     (halted),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain queue stack, mode number, fault code, PC count.
    logic [15:0] m_stack [$];
    int          m_mode;
    logic [1:0]  m_fc;
    logic [15:0] pc;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    task automatic check_status(input string pfx);
        check_val({pfx, "_sp"}, 32'(sp), 32'(m_stack.size()));
        check_val({pfx, "_halted"}, 32'(halted), 32'(m_mode == M_HALT));
        check_val({pfx, "_fault"}, 32'(fault), 32'(m_mode == M_FAULT));
        check_val({pfx, "_fcode"}, 32'(fault_code), 32'(m_fc));
    endtask

    // One clock: drive, compare combinational/status outputs, clock, update model.
    task automatic cycle(input logic v, input logic [2:0] code, input logic [15:0] tgt,
                         input logic cz, input logic rs);
        logic        e_le;
        logic [15:0] e_la;
        logic [15:0] cur;
        logic        do_push, do_pop;
        int          n_mode;
        logic [1:0]  n_fc;
        bus.pc_in        = pc;
        bus.execute_flag = pc[0];
        bus.op_valid     = v;
        bus.op_code      = code;
        bus.op_target    = tgt;
        bus.cond_zero    = cz;
        bus.resume       = rs;
        cur     = {1'b0, pc[15:1]};
        e_le    = 1'b0;
        e_la    = 16'h0;
        do_push = 1'b0;
        do_pop  = 1'b0;
        n_mode  = m_mode;
        n_fc    = m_fc;
        if (pc[0]) begin
            if (m_mode == M_RUN && v) begin
                if (code == 3'd1) begin
                    e_le = 1'b1; e_la = tgt;
                end else if (code == 3'd2 && cz) begin
                    e_le = 1'b1; e_la = tgt;
                end else if (code == 3'd3 && !cz) begin
                    e_le = 1'b1; e_la = tgt;
                end else if (code == 3'd4) begin
                    if (m_stack.size() < DEPTH) begin
                        e_le = 1'b1; e_la = tgt; do_push = 1'b1;
                    end else begin
                        n_mode = M_FAULT; n_fc = 2'b01;
                    end
                end else if (code == 3'd5) begin
                    if (m_stack.size() > 0) begin
                        e_le = 1'b1; e_la = m_stack[$]; do_pop = 1'b1;
                    end else begin
                        n_mode = M_FAULT; n_fc = 2'b10;
                    end
                end else if (code == 3'd6) begin
                    e_le = 1'b1; e_la = cur; n_mode = M_HALT;
                end
            end else if (m_mode == M_HALT) begin
                if (rs) n_mode = M_RUN;
                else begin
                    e_le = 1'b1; e_la = cur;
                end
            end else if (m_mode == M_FAULT) begin
                e_le = 1'b1; e_la = cur;
            end
        end
        #2;
        check_val("load_enable", 32'(bus.load_enable), 32'(e_le));
        if (e_le) check_val("load_addr", 32'(bus.load_addr), 32'(e_la));
        check_status("st");
        @(posedge clk);
        if (do_push) m_stack.push_back(cur + 16'd1);
        if (do_pop) void'(m_stack.pop_back());
        m_mode = n_mode;
        m_fc   = n_fc;
        pc     = e_le ? {e_la[14:0], 1'b0} : pc + 16'd1;
        #1;
    endtask

    // Issue an op on the next execute phase, idling through a fetch phase if needed.
    task automatic exec_op(input logic [2:0] code, input logic [15:0] tgt,
                           input logic cz, input logic rs);
        if (!pc[0]) cycle(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, code, tgt, cz, rs);
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.pc_in        = pc | 16'h1;
        bus.execute_flag = 1'b1;
        bus.op_valid     = 1'b1;
        bus.op_code      = 3'd1;
        bus.op_target    = 16'h1234;
        #1;
        m_stack.delete();
        m_mode = M_RUN;
        m_fc   = 2'b00;
        check_val("rst_load_enable", 32'(bus.load_enable), 32'd0);
        check_status("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        pc               = 16'h0;
        m_mode           = M_RUN;
        m_fc             = 2'b00;
        bus.pc_in        = 16'h0;
        bus.execute_flag = 1'b0;
        bus.op_valid     = 1'b0;
        bus.op_code      = 3'd0;
        bus.op_target    = 16'h0;
        bus.cond_zero    = 1'b0;
        bus.resume       = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // JMP, then the following fetch phase must not load.
        pc = 16'h0009;
        cycle(1'b1, 3'd1, 16'h0040, 1'b0, 1'b0);
        check_val("jmp_next_pc_model", 32'(bus.load_addr), 32'h0040);
        cycle(1'b1, 3'd1, 16'h0777, 1'b0, 1'b0);

        // JZ not taken, JNZ taken.
        exec_op(3'd2, 16'h0050, 1'b0, 1'b0);
        exec_op(3'd3, 16'h0012, 1'b0, 1'b0);

        // CALL at 0x0021 then RET back to 0x0011.
        pc = 16'h0021;
        cycle(1'b1, 3'd4, 16'h0100, 1'b0, 1'b0);
        check_val("call_sp", 32'(sp), 32'd1);
        exec_op(3'd5, 16'h0, 1'b0, 1'b0);
        check_val("ret_sp", 32'(sp), 32'd0);

        // DEPTH nested calls unwind LIFO.
        for (int i = 0; i < DEPTH; i++) exec_op(3'd4, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) exec_op(3'd5, 16'h0, 1'b0, 1'b0);

        // Overflow on the DEPTH+1th call; holds through resume until reset.
        for (int i = 0; i <= DEPTH; i++) exec_op(3'd4, 16'($urandom), 1'b0, 1'b0);
        check_val("ovf_fcode", 32'(fault_code), 32'h1);
        check_val("ovf_sp", 32'(sp), 32'(DEPTH));
        for (int i = 0; i < 6; i++) cycle(1'b1, 3'd5, 16'h0, 1'b0, 1'b1);
        do_reset();

        // Underflow.
        exec_op(3'd5, 16'h0, 1'b0, 1'b0);
        check_val("udf_fcode", 32'(fault_code), 32'h2);
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd4, 16'h0, 1'b0, 1'b1);
        do_reset();

        // HALT at word 0x0030, spin, then resume.
        pc = 16'h0061;
        cycle(1'b1, 3'd6, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 3'd1, 16'h0999, 1'b0, 1'b0);
        exec_op(3'd0, 16'h0, 1'b0, 1'b1);
        check_val("resume_pc_word", 32'(halted), 32'd0);
        cycle(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);

        // Reset between calls with sp=3.
        for (int i = 0; i < 3; i++) exec_op(3'd4, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if (($urandom % 300) == 0 || (m_mode == M_FAULT && ($urandom % 10) == 0)) begin
                do_reset();
            end else begin
                cycle(1'($urandom % 4 != 0), 3'($urandom), 16'($urandom),
                      1'($urandom), 1'($urandom % 5 == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
